// File: rtl/fir_s2p_unfold.sv
// Serial-to-parallel packer feeding the 3-way unfolded FIR.
// Collects WIDTH-bit samples into L-lane groups and emits each group as one
// word with a single-cycle VOUT pulse. FLUSH emits a zero-padded partial
// group at end of stream. Lane 0 carries the oldest sample.
module fir_s2p_unfold #(
  parameter int WIDTH = 11,
  parameter int L     = 3,
  parameter int CW    = 2
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic signed [WIDTH-1:0] DIN,
  input  logic                    VIN,
  input  logic                    FLUSH,
  output logic [L*WIDTH-1:0]      DOUT,
  output logic                    VOUT,
  output logic [CW-1:0]           NVALID
);

  // Fill count: number of samples already staged for the current group.
  logic [CW-1:0]      cnt_reg;
  logic [CW-1:0]      cnt_next;
  logic [CW-1:0]      nvalid_next;
  logic [WIDTH-1:0]   stage_reg [L];
  logic [L*WIDTH-1:0] group_next;
  logic               group_full;
  logic               emit;
  logic [L*WIDTH-1:0] dout_reg;
  logic               vout_reg;
  logic [CW-1:0]      nvalid_reg;

  // Lanes at or above cnt_reg are always zero in the staging array (cleared on
  // every emission and on reset), so merging the incoming sample into its lane
  // yields the correctly zero-padded output word for both full and flushed
  // groups without any extra masking.
  genvar gi;
  generate
    for (gi = 0; gi < L; gi++) begin : g_lane
      assign group_next[gi*WIDTH +: WIDTH] =
        (VIN && (cnt_reg == CW'(gi))) ? DIN : stage_reg[gi];

      // Staging lane: capture the sample addressed to this lane, clear on emit.
      always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
          stage_reg[gi] <= '0;
        end else if (emit) begin
          stage_reg[gi] <= '0;
        end else if (VIN && (cnt_reg == CW'(gi))) begin
          stage_reg[gi] <= DIN;
        end
      end
    end
  endgenerate

  // Emission decision: a completed group, or a flush with at least one sample
  // (a sample arriving alongside FLUSH counts, and is accepted first).
  always_comb begin
    group_full  = VIN && (cnt_reg == CW'(L - 1));
    emit        = group_full || (FLUSH && (VIN || (cnt_reg != '0)));
    nvalid_next = VIN ? (cnt_reg + CW'(1)) : cnt_reg;
    if (emit) begin
      cnt_next = '0;
    end else if (VIN) begin
      cnt_next = cnt_reg + CW'(1);
    end else begin
      cnt_next = cnt_reg;
    end
  end

  // Fill counter: advances on each accepted sample, returns to zero on emit.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

  // Registered outputs: VOUT pulses for one cycle, DOUT/NVALID hold until the
  // next emission.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      dout_reg   <= '0;
      vout_reg   <= 1'b0;
      nvalid_reg <= '0;
    end else begin
      vout_reg <= emit;
      if (emit) begin
        dout_reg   <= group_next;
        nvalid_reg <= nvalid_next;
      end
    end
  end

  assign DOUT   = dout_reg;
  assign VOUT   = vout_reg;
  assign NVALID = nvalid_reg;

endmodule

// File: tb/tb_fir_s2p_unfold.sv
// Testbench for fir_s2p_unfold: scenario tasks checked against a queue-based
// reference model of the packing rules.
module tb_fir_s2p_unfold;
  localparam int WIDTH = 11;
  localparam int L     = 3;
  localparam int CW    = 2;

  logic                    CLK = 1'b0;
  logic                    RST = 1'b1;
  logic signed [WIDTH-1:0] DIN = '0;
  logic                    VIN = 1'b0;
  logic                    FLUSH = 1'b0;
  logic [L*WIDTH-1:0]      DOUT;
  logic                    VOUT;
  logic [CW-1:0]           NVALID;

  fir_s2p_unfold #(.WIDTH(WIDTH), .L(L), .CW(CW)) dut (
    .CLK   (CLK),
    .RST   (RST),
    .DIN   (DIN),
    .VIN   (VIN),
    .FLUSH (FLUSH),
    .DOUT  (DOUT),
    .VOUT  (VOUT),
    .NVALID(NVALID)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: pending samples in arrival order plus expected outputs.
  logic [WIDTH-1:0]   pend[$];
  logic [L*WIDTH-1:0] exp_dout = '0;
  logic [CW-1:0]      exp_nv   = '0;
  logic               exp_vout = 1'b0;

  typedef struct {
    bit vin;
    int din;
    bit flush;
  } step_t;
  step_t seq[$];

  task automatic add(input bit v, input int d, input bit f);
    step_t s;
    s.vin = v; s.din = d; s.flush = f;
    seq.push_back(s);
  endtask

  task automatic model_reset();
    pend.delete();
    exp_dout = '0;
    exp_nv   = '0;
    exp_vout = 1'b0;
  endtask

  // Apply one cycle of stimulus, then advance the model by the same cycle.
  task automatic drive(input step_t s);
    int d;
    d     = s.din;
    VIN   = s.vin;
    DIN   = d[WIDTH-1:0];
    FLUSH = s.flush;
    @(posedge CLK);
    #1;
    if (s.vin) pend.push_back(d[WIDTH-1:0]);
    if (pend.size() == L || (s.flush && pend.size() > 0)) begin
      exp_dout = '0;
      for (int i = 0; i < pend.size(); i++) exp_dout[i*WIDTH +: WIDTH] = pend[i];
      exp_nv   = CW'(pend.size());
      exp_vout = 1'b1;
      pend.delete();
    end else begin
      exp_vout = 1'b0;
    end
    VIN   = 1'b0;
    FLUSH = 1'b0;
    if (VOUT) $display("emit t=%0t nvalid=%0d dout=%h", $time, NVALID, DOUT);
  endtask

  task automatic test_reset();
    @(posedge CLK); @(posedge CLK); #1;
    n_checks += 3;
    if (VOUT !== 1'b0) begin n_fail++; $display("FAIL reset_vout got %b want 0", VOUT); end
    if (DOUT !== '0) begin n_fail++; $display("FAIL reset_dout got %h want 0", DOUT); end
    if (NVALID !== '0) begin n_fail++; $display("FAIL reset_nvalid got %0d want 0", NVALID); end
    @(negedge CLK);
    RST = 1'b0;
    model_reset();
  endtask

  task automatic test_basic();
    seq.delete();
    add(1, 1, 0); add(1, 2, 0); add(1, 3, 0); add(0, 0, 0); add(0, 0, 0);
    foreach (seq[k]) begin
      drive(seq[k]);
      n_checks += 3;
      if (VOUT !== exp_vout) begin n_fail++; $display("FAIL basic_vout step %0d got %b want %b", k, VOUT, exp_vout); end
      if (DOUT !== exp_dout) begin n_fail++; $display("FAIL basic_dout step %0d got %h want %h", k, DOUT, exp_dout); end
      if (NVALID !== exp_nv) begin n_fail++; $display("FAIL basic_nvalid step %0d got %0d want %0d", k, NVALID, exp_nv); end
    end
    n_checks += 2;
    if (DOUT !== {11'd3, 11'd2, 11'd1}) begin n_fail++; $display("FAIL basic_lanes got %h want {3,2,1}", DOUT); end
    if (NVALID !== 2'd3) begin n_fail++; $display("FAIL basic_nv3 got %0d want 3", NVALID); end
  endtask

  task automatic test_extremes();
    seq.delete();
    add(1, -1024, 0);
    add(1, 1023, 0);
    add(0, 0, 0); add(0, 0, 0);
    add(1, -1, 0);
    repeat (5) add(0, 0, 0);
    foreach (seq[k]) begin
      drive(seq[k]);
      n_checks += 3;
      if (VOUT !== exp_vout) begin n_fail++; $display("FAIL extreme_vout step %0d got %b want %b", k, VOUT, exp_vout); end
      if (DOUT !== exp_dout) begin n_fail++; $display("FAIL extreme_dout step %0d got %h want %h", k, DOUT, exp_dout); end
      if (NVALID !== exp_nv) begin n_fail++; $display("FAIL extreme_nvalid step %0d got %0d want %0d", k, NVALID, exp_nv); end
    end
    n_checks += 1;
    if (DOUT !== {11'h7FF, 11'h3FF, 11'h400}) begin n_fail++; $display("FAIL extreme_lanes got %h want 7ff/3ff/400", DOUT); end
  endtask

  task automatic test_back_to_back();
    int pulses;
    int last_pulse;
    pulses = 0;
    last_pulse = -1;
    seq.delete();
    for (int v = 10; v <= 18; v++) add(1, v, 0);
    add(0, 0, 0);
    foreach (seq[k]) begin
      drive(seq[k]);
      n_checks += 3;
      if (VOUT !== exp_vout) begin n_fail++; $display("FAIL b2b_vout step %0d got %b want %b", k, VOUT, exp_vout); end
      if (DOUT !== exp_dout) begin n_fail++; $display("FAIL b2b_dout step %0d got %h want %h", k, DOUT, exp_dout); end
      if (NVALID !== exp_nv) begin n_fail++; $display("FAIL b2b_nvalid step %0d got %0d want %0d", k, NVALID, exp_nv); end
      if (VOUT === 1'b1) begin
        if (last_pulse >= 0) begin
          n_checks++;
          if (k - last_pulse != L) begin n_fail++; $display("FAIL b2b_spacing got %0d want %0d", k - last_pulse, L); end
        end
        last_pulse = k;
        pulses++;
      end
    end
    n_checks++;
    if (pulses != 3) begin n_fail++; $display("FAIL b2b_pulses got %0d want 3", pulses); end
  endtask

  task automatic test_flush();
    seq.delete();
    add(1, 5, 0); add(1, 6, 0); add(0, 0, 1);
    add(0, 0, 1);
    add(1, 7, 0); add(1, 8, 1);
    add(1, 9, 0); add(0, 0, 1);
    add(1, 1, 0); add(1, 2, 0); add(1, 3, 1);
    add(0, 0, 0);
    foreach (seq[k]) begin
      drive(seq[k]);
      n_checks += 3;
      if (VOUT !== exp_vout) begin n_fail++; $display("FAIL flush_vout step %0d got %b want %b", k, VOUT, exp_vout); end
      if (DOUT !== exp_dout) begin n_fail++; $display("FAIL flush_dout step %0d got %h want %h", k, DOUT, exp_dout); end
      if (NVALID !== exp_nv) begin n_fail++; $display("FAIL flush_nvalid step %0d got %0d want %0d", k, NVALID, exp_nv); end
      if (k == 2) begin
        n_checks++;
        if (DOUT !== {11'd0, 11'd6, 11'd5}) begin n_fail++; $display("FAIL flush_pad got %h want {0,6,5}", DOUT); end
      end
      if (k == 5) begin
        n_checks++;
        if (DOUT !== {11'd0, 11'd8, 11'd7} || NVALID !== 2'd2) begin
          n_fail++; $display("FAIL flush_with_vin got %h/%0d want {0,8,7}/2", DOUT, NVALID);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    seq.delete();
    add(1, 4, 0); add(1, 5, 0);
    foreach (seq[k]) drive(seq[k]);
    #3 RST = 1'b1;
    #1;
    model_reset();
    n_checks += 3;
    if (VOUT !== 1'b0) begin n_fail++; $display("FAIL rstmid_vout got %b want 0", VOUT); end
    if (DOUT !== '0) begin n_fail++; $display("FAIL rstmid_dout got %h want 0", DOUT); end
    if (NVALID !== '0) begin n_fail++; $display("FAIL rstmid_nvalid got %0d want 0", NVALID); end
    @(posedge CLK); #1;
    n_checks++;
    if (DOUT !== '0 || VOUT !== 1'b0) begin n_fail++; $display("FAIL rstmid_hold got %h/%b want 0/0", DOUT, VOUT); end
    @(negedge CLK);
    RST = 1'b0;
    seq.delete();
    add(1, 6, 0); add(1, 7, 0); add(1, 8, 0); add(0, 0, 0);
    foreach (seq[k]) begin
      drive(seq[k]);
      n_checks += 3;
      if (VOUT !== exp_vout) begin n_fail++; $display("FAIL rstmid2_vout step %0d got %b want %b", k, VOUT, exp_vout); end
      if (DOUT !== exp_dout) begin n_fail++; $display("FAIL rstmid2_dout step %0d got %h want %h", k, DOUT, exp_dout); end
      if (NVALID !== exp_nv) begin n_fail++; $display("FAIL rstmid2_nvalid step %0d got %0d want %0d", k, NVALID, exp_nv); end
    end
    n_checks++;
    if (DOUT !== {11'd8, 11'd7, 11'd6}) begin n_fail++; $display("FAIL rstmid_lanes got %h want {8,7,6}", DOUT); end
  endtask

  task automatic test_random();
    seq.delete();
    for (int k = 0; k < 300; k++) begin
      add($urandom_range(99) < 60, int'($urandom_range(2047)) - 1024, $urandom_range(99) < 10);
    end
    add(0, 0, 1);
    add(0, 0, 0);
    foreach (seq[k]) begin
      drive(seq[k]);
      n_checks += 3;
      if (VOUT !== exp_vout) begin n_fail++; $display("FAIL rand_vout step %0d got %b want %b", k, VOUT, exp_vout); end
      if (DOUT !== exp_dout) begin n_fail++; $display("FAIL rand_dout step %0d got %h want %h", k, DOUT, exp_dout); end
      if (NVALID !== exp_nv) begin n_fail++; $display("FAIL rand_nvalid step %0d got %0d want %0d", k, NVALID, exp_nv); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_extremes();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
